// File: rtl/control_fsm.sv
// Multi-cycle control unit: latches the fetched instruction into IR and sequences
// decode/execute/memory/writeback, driving datapath enables and the PC load/select.
module control_fsm #(
  parameter logic [3:0] ALU_ADD = 4'b0000,
  parameter logic [3:0] ALU_SUB = 4'b0001,
  parameter logic [3:0] ALU_AND = 4'b0010,
  parameter logic [3:0] ALU_OR  = 4'b0011
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  output logic [31:0] PC_Immed,
  output logic        PC_sel,
  output logic        PC_LdEn,
  output logic        RF_WrEn,
  output logic        RF_B_sel,
  output logic        RF_WrData_sel,
  output logic        ALU_Bin_sel,
  output logic [1:0]  ImmExt_sel,
  output logic [3:0]  ALU_func,
  output logic        MEM_WrEn,
  output logic [3:0]  State
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] EXEC_R   = 4'd2;
  localparam logic [3:0] EXEC_I   = 4'd3;
  localparam logic [3:0] WB_ALU   = 4'd4;
  localparam logic [3:0] MEM_ADDR = 4'd5;
  localparam logic [3:0] MEM_RD   = 4'd6;
  localparam logic [3:0] WB_MEM   = 4'd7;
  localparam logic [3:0] MEM_WR   = 4'd8;
  localparam logic [3:0] BRANCH   = 4'd9;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SW    = 6'b011111;

  logic [3:0]  state, next_state;
  logic [31:0] ir;
  logic [5:0]  opcode;
  logic        is_imm, is_branch;
  logic [3:0]  imm_func;
  logic [1:0]  imm_ext;

  assign opcode    = ir[31:26];
  assign is_imm    = opcode inside {OP_LI, OP_LUI, OP_ADDI, OP_ANDI, OP_ORI};
  assign is_branch = opcode inside {OP_B, OP_BEQ, OP_BNE};
  assign PC_Immed  = {{14{ir[15]}}, ir[15:0], 2'b00};
  assign State     = state;

  // Register-address fields of IR are consumed by the datapath, not here.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[25:16];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= FETCH;
      ir    <= '0;
    end else begin
      state <= next_state;
      if (state == FETCH) ir <= Instr;
    end
  end

  always_comb begin
    imm_func = ALU_ADD;
    imm_ext  = 2'd0;
    unique case (opcode)
      OP_LUI:  imm_ext = 2'd2;
      OP_ANDI: begin imm_func = ALU_AND; imm_ext = 2'd1; end
      OP_ORI:  begin imm_func = ALU_OR;  imm_ext = 2'd1; end
      default: ;
    endcase
  end

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:    next_state = DECODE;
      DECODE: begin
        if (opcode == OP_RTYPE)                      next_state = EXEC_R;
        else if (is_imm)                             next_state = EXEC_I;
        else if (opcode == OP_LW || opcode == OP_SW) next_state = MEM_ADDR;
        else if (is_branch)                          next_state = BRANCH;
        else                                         next_state = FETCH;
      end
      EXEC_R:   next_state = WB_ALU;
      EXEC_I:   next_state = WB_ALU;
      MEM_ADDR: next_state = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   next_state = WB_MEM;
      default:  next_state = FETCH;
    endcase
  end

  always_comb begin
    PC_sel        = 1'b0;
    PC_LdEn       = 1'b0;
    RF_WrEn       = 1'b0;
    RF_B_sel      = 1'b0;
    RF_WrData_sel = 1'b0;
    ALU_Bin_sel   = 1'b0;
    ImmExt_sel    = 2'd0;
    ALU_func      = ALU_ADD;
    MEM_WrEn      = 1'b0;
    case (state)
      DECODE: begin
        RF_B_sel = opcode inside {OP_SW, OP_BEQ, OP_BNE};
        // Illegal opcodes retire here as a NOP.
        if (!(opcode == OP_RTYPE || is_imm || is_branch ||
              opcode == OP_LW || opcode == OP_SW))
          PC_LdEn = 1'b1;
      end
      EXEC_R: ALU_func = ir[3:0];
      EXEC_I: begin
        ALU_Bin_sel = 1'b1;
        ALU_func    = imm_func;
        ImmExt_sel  = imm_ext;
      end
      WB_ALU: begin
        RF_WrEn = 1'b1;
        PC_LdEn = 1'b1;
        if (opcode == OP_RTYPE) begin
          ALU_func = ir[3:0];
        end else begin
          ALU_Bin_sel = 1'b1;
          ALU_func    = imm_func;
          ImmExt_sel  = imm_ext;
        end
      end
      MEM_ADDR, MEM_RD: ALU_Bin_sel = 1'b1;
      WB_MEM: begin
        RF_WrEn       = 1'b1;
        RF_WrData_sel = 1'b1;
        PC_LdEn       = 1'b1;
      end
      MEM_WR: begin
        MEM_WrEn = 1'b1;
        RF_B_sel = 1'b1;
        PC_LdEn  = 1'b1;
      end
      BRANCH: begin
        RF_B_sel = 1'b1;
        ALU_func = ALU_SUB;
        PC_LdEn  = 1'b1;
        PC_sel   = (opcode == OP_B) | ((opcode == OP_BEQ) & Zero) |
                   ((opcode == OP_BNE) & ~Zero);
      end
      default: ;
    endcase
  end

endmodule
